ofmap_packer: RTL and testbench

// - Downstream of the accelerator top: consumes the PPU output stream (valid/ofmap/done) and packs it for DRAM write-back.
// - Mode 0: packs four int8 results (low byte of each ofmap word) into one 32-bit word, little-endian.
// - Mode 1 (MLP3 step 0): passes full 32-bit partial sums unchanged.
// - The producer has no backpressure, so an elastic FIFO absorbs DRAM stalls; overrun is flagged, never silent.

---
 rtl/ofmap_packer_pkg.sv | 30 +++
 rtl/ofmap_packer_fifo.sv | 76 +++++++
 rtl/ofmap_packer.sv | 175 +++++++++++++++++
 tb/tb_ofmap_packer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofmap_packer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : ofmap_pkg                                                       |
// | Purpose  : Shared types and constants for the ofmap write-back packer:     |
// |            FSM state encoding, packing-mode codes and lane arithmetic.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package ofmap_pkg;

    // Packer FSM states, explicitly encoded in two bits.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } packer_state_e;

    localparam int DATA_SIZE_DEF  = 32;
    localparam int BYTES_PER_WORD = DATA_SIZE_DEF / 8;

    localparam logic MODE_INT8 = 1'b0;
    localparam logic MODE_RAW  = 1'b1;

    // Number of int8 lanes that fit in a word of the given width.
    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ofmap_packer_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sync_fifo                                                       |
// | Purpose  : Single-clock show-ahead FIFO. The head entry is visible on      |
// |            o_rd_data whenever o_empty is low; i_rd_en pops it.             |
// |            A write while full is accepted only if a pop happens in the     |
// |            same cycle, otherwise it is discarded.                          |
// | Ports    : clk, rst (async, active high)                                   |
// |            i_wr_en / i_wr_data  push side                                  |
// |            i_rd_en / o_rd_data  pop side (show-ahead)                      |
// |            o_full, o_empty, o_count  occupancy                             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic w_do_rd;
    logic w_do_wr;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_DEPTH_CNT);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    assign w_do_rd = i_rd_en && !o_empty;
    // A simultaneous pop frees the slot, so a write into a full FIFO still lands.
    assign w_do_wr = i_wr_en && (!o_full || w_do_rd);

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ofmap_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ofmap_packer                                                    |
// | Purpose  : Packs the PPU output stream for DRAM write-back. Mode 0 packs   |
// |            the low byte of four results into one little-endian word;       |
// |            mode 1 passes full words through. An elastic FIFO absorbs DRAM  |
// |            stalls; dropped words raise a sticky overflow flag.             |
// | Ports    : clk, rst (async, active high)                                   |
// |            mode, in_valid, in_data, in_done      producer side             |
// |            out_valid, out_ready, out_data, out_last  DRAM side             |
// |            word_cnt, overflow, flush_done        status                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ofmap_packer
    import ofmap_pkg::*;
#(
    parameter int DATA_SIZE  = DATA_SIZE_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic                 in_done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_last,
    output logic [CNT_W-1:0]     word_cnt,
    output logic                 overflow,
    output logic                 flush_done
);
    localparam int c_LANES  = bytes_per_word(DATA_SIZE);
    localparam int c_LANE_W = (c_LANES > 1) ? $clog2(c_LANES) : 1;
    localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(c_LANES - 1);
    localparam int c_FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_FCNT_W-1:0] c_ONE_WORD = c_FCNT_W'(1);

    packer_state_e        r_state;
    logic                 r_mode;
    logic [c_LANE_W-1:0]  r_lane;
    logic [DATA_SIZE-1:0] r_pack;
    logic [CNT_W-1:0]     r_word_cnt;
    logic                 r_overflow;
    logic                 r_flush_done;

    logic                 w_accept;
    logic                 w_mode;
    logic                 w_lane_full;
    logic                 w_flush_partial;
    logic                 w_push;
    logic [DATA_SIZE-1:0] w_push_data;
    logic [DATA_SIZE-1:0] w_pack_next;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_full;
    logic                 w_empty;
    logic [c_FCNT_W-1:0]  w_count;
    logic [DATA_SIZE-1:0] w_fifo_data;

    // Data is only taken while a layer is open (or opening); the first beat
    // uses the live mode input because the latched copy is written that cycle.
    assign w_accept        = in_valid && ((r_state == IDLE) || (r_state == RUN));
    assign w_mode          = (r_state == IDLE) ? mode : r_mode;
    assign w_lane_full     = (r_lane == c_LAST_LANE);
    assign w_flush_partial = (r_state == FLUSH) && (r_lane != '0);

    always_comb begin
        w_pack_next = r_pack;
        w_pack_next[{r_lane, 3'b000} +: 8] = in_data[7:0];
    end

    assign w_push = (w_accept && ((w_mode == MODE_RAW) || w_lane_full)) || w_flush_partial;

    always_comb begin
        w_push_data = w_pack_next;
        if (w_flush_partial) begin
            w_push_data = r_pack;
        end else if (w_mode == MODE_RAW) begin
            w_push_data = in_data;
        end
    end

    assign w_pop  = out_ready && !w_empty;
    assign w_drop = w_push && w_full && !w_pop;

    sync_fifo #(
        .WIDTH (DATA_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_data (w_push_data),
        .i_rd_en   (out_ready),
        .o_rd_data (w_fifo_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    assign out_valid  = !w_empty;
    assign out_data   = w_empty ? '0 : w_fifo_data;
    // The final word is identifiable once the layer is closed: in DRAIN, or
    // already in FLUSH when no partial word is still waiting to be pushed.
    assign out_last   = (w_count == c_ONE_WORD) &&
                        ((r_state == DRAIN) || ((r_state == FLUSH) && (r_lane == '0)));
    assign word_cnt   = r_word_cnt;
    assign overflow   = r_overflow;
    assign flush_done = r_flush_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_mode       <= MODE_INT8;
            r_lane       <= '0;
            r_pack       <= '0;
            r_word_cnt   <= '0;
            r_overflow   <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;

            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end

            if (w_accept && (w_mode == MODE_INT8)) begin
                if (w_lane_full) begin
                    r_lane <= '0;
                    r_pack <= '0;
                end else begin
                    r_lane <= r_lane + 1'b1;
                    r_pack <= w_pack_next;
                end
            end

            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mode     <= mode;
                        r_word_cnt <= '0;
                        r_state    <= in_done ? FLUSH : RUN;
                    end else if (in_done) begin
                        r_flush_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (in_done) begin
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    r_lane  <= '0;
                    r_pack  <= '0;
                    r_state <= DRAIN;
                end
                DRAIN: begin
                    if (w_empty) begin
                        r_flush_done <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ofmap_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ofmap_packer                                                 |
// | Purpose  : Self-checking bench for ofmap_packer. A queue-based layer model |
// |            predicts the DRAM-side outputs every cycle; directed layers pin |
// |            the model with literal expectations, random layers follow.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ofmap_packer;

    localparam int DEPTH    = 8;
    localparam int PH_IDLE  = 0;
    localparam int PH_OPEN  = 1;
    localparam int PH_CLOSE = 2;
    localparam int PH_DRAIN = 3;

    logic        clk;
    logic        rst;
    logic        mode;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_done;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic [11:0] word_cnt;
    logic        overflow;
    logic        flush_done;

    ofmap_packer #(
        .DATA_SIZE  (32),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_done    (in_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .word_cnt   (word_cnt),
        .overflow   (overflow),
        .flush_done (flush_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int fd_seen = 0;

    logic [31:0] log_d [$];
    logic        log_l [$];

    // Layer model: words waiting for DRAM, bytes of the unfinished int8 word.
    logic [31:0] m_q [$];
    logic [7:0]  m_bytes [$];
    int          m_phase;
    logic        m_mode;
    logic [11:0] m_cnt;
    logic        m_ovf;
    logic        m_fd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_bytes();
        logic [31:0] w;
        w = '0;
        foreach (m_bytes[i]) w[8*i +: 8] = m_bytes[i];
        return w;
    endfunction

    function automatic logic exp_last();
        return (m_q.size() == 1) &&
               ((m_phase == PH_DRAIN) || ((m_phase == PH_CLOSE) && (m_bytes.size() == 0)));
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_bytes.delete();
        m_phase = PH_IDLE;
        m_mode  = 1'b0;
        m_cnt   = '0;
        m_ovf   = 1'b0;
        m_fd    = 1'b0;
    endtask

    task automatic model_push(input logic [31:0] w);
        if (m_q.size() < DEPTH) m_q.push_back(w);
        else m_ovf = 1'b1;
    endtask

    task automatic model_take(input logic [31:0] d);
        if (m_mode) begin
            model_push(d);
        end else begin
            m_bytes.push_back(d[7:0]);
            if (m_bytes.size() == 4) begin
                model_push(pack_bytes());
                m_bytes.delete();
            end
        end
    endtask

    // Predicts the effect of the coming rising edge from the inputs held now.
    task automatic model_step();
        bit was_empty;
        was_empty = (m_q.size() == 0);
        m_fd = 1'b0;
        if (!was_empty && out_ready) begin
            m_q.delete(0);
            m_cnt = m_cnt + 12'd1;
        end
        case (m_phase)
            PH_IDLE: begin
                if (in_valid) begin
                    m_mode  = mode;
                    m_cnt   = '0;
                    model_take(in_data);
                    m_phase = in_done ? PH_CLOSE : PH_OPEN;
                end else if (in_done) begin
                    m_fd = 1'b1;
                end
            end
            PH_OPEN: begin
                if (in_valid) model_take(in_data);
                if (in_done) m_phase = PH_CLOSE;
            end
            PH_CLOSE: begin
                if (m_bytes.size() != 0) begin
                    model_push(pack_bytes());
                    m_bytes.delete();
                end
                m_phase = PH_DRAIN;
            end
            default: begin
                if (was_empty) begin
                    m_fd    = 1'b1;
                    m_phase = PH_IDLE;
                end
            end
        endcase
    endtask

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (rst) model_reset();
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
        chk("out_last", 32'(out_last), 32'(exp_last()));
        chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("flush_done", 32'(flush_done), 32'(m_fd));
        if (out_valid && out_ready) begin
            log_d.push_back(out_data);
            log_l.push_back(out_last);
        end
        if (flush_done) fd_seen++;
        if (!rst) model_step();
    end

    task automatic step(input logic v, input logic [31:0] d, input logic dn, input logic rdy);
        in_valid  = v;
        in_data   = d;
        in_done   = dn;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd_ready();
        return ($urandom % 4) != 0;
    endfunction

    task automatic wait_fd(input int budget, input bit rnd);
        int start;
        int n;
        start = fd_seen;
        n = 0;
        while ((fd_seen == start) && (n < budget)) begin
            step(1'b0, 32'h0, 1'b0, rnd ? rnd_ready() : 1'b1);
            n++;
        end
        checks++;
        if (fd_seen == start) begin
            errors++;
            $display("FAIL wait_fd: flush_done not seen within %0d cycles", budget);
        end
    endtask

    task automatic clear_log();
        log_d.delete();
        log_l.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          fd0;
    int          nb;
    bit          cc;
    logic [31:0] exp_w [$];

    initial begin
        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; in_done = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_flush_done", 32'(flush_done), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        rst = 1'b0;
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Mode 0: eight bytes -> two packed words, final one marked last.
        clear_log(); mode = 1'b0; fd0 = fd_seen;
        for (int i = 1; i <= 8; i++) step(1'b1, 32'(i * 32'h11), (i == 8), 1'b1);
        wait_fd(40, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t1_nwords", 32'(log_d.size()), 32'd2);
        if (log_d.size() == 2) begin
            chk("t1_w0", log_d[0], 32'h44332211);
            chk("t1_w1", log_d[1], 32'h88776655);
            chk("t1_last0", 32'(log_l[0]), 32'd0);
            chk("t1_last1", 32'(log_l[1]), 32'd1);
        end
        chk("t1_word_cnt", 32'(word_cnt), 32'd2);
        chk("t1_fd_count", 32'(fd_seen - fd0), 32'd1);

        // Mode 0: six bytes, partial second word zero-padded.
        clear_log(); mode = 1'b0;
        for (int i = 1; i <= 6; i++) step(1'b1, 32'(i) | 32'hABCDEF00, (i == 6), 1'b1);
        wait_fd(40, 1'b0);
        chk("t2_nwords", 32'(log_d.size()), 32'd2);
        if (log_d.size() == 2) begin
            chk("t2_w0", log_d[0], 32'h04030201);
            chk("t2_w1", log_d[1], 32'h00000605);
            chk("t2_last1", 32'(log_l[1]), 32'd1);
        end

        // Mode 1: passthrough of three full words.
        clear_log(); mode = 1'b1;
        step(1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
        step(1'b1, 32'h12345678, 1'b0, 1'b1);
        step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b1);
        wait_fd(40, 1'b0);
        chk("t3_nwords", 32'(log_d.size()), 32'd3);
        if (log_d.size() == 3) begin
            chk("t3_w0", log_d[0], 32'hDEADBEEF);
            chk("t3_w1", log_d[1], 32'h12345678);
            chk("t3_w2", log_d[2], 32'hFFFFFFFF);
            chk("t3_last", 32'({log_l[0], log_l[1], log_l[2]}), 32'b001);
        end
        chk("t3_word_cnt", 32'(word_cnt), 32'd3);

        // in_done with no data: flush_done only, no words.
        clear_log(); fd0 = fd_seen;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t6_fd_count", 32'(fd_seen - fd0), 32'd1);
        chk("t6_no_words", 32'(log_d.size()), 32'd0);

        // Mode 1 overrun: ten pushes into an eight-deep FIFO with DRAM stalled.
        clear_log(); mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'hA0000000 + 32'(i), 1'b0, 1'b0);
            if (i == 7) chk("t4_ovf_after8", 32'(overflow), 32'd0);
            if (i == 8) chk("t4_ovf_after9", 32'(overflow), 32'd1);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("t4_stall_data_a", out_data, 32'hA0000000);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("t4_stall_data_b", out_data, 32'hA0000000);
        wait_fd(40, 1'b0);
        chk("t4_nwords", 32'(log_d.size()), 32'd8);
        if (log_d.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("t4_word", log_d[i], 32'hA0000000 + 32'(i));
            chk("t4_last", 32'(log_l[7]), 32'd1);
        end
        chk("t4_ovf_sticky", 32'(overflow), 32'd1);

        // Reset while draining three queued words.
        clear_log(); mode = 1'b1;
        step(1'b1, 32'hC0C0C0C0, 1'b0, 1'b0);
        step(1'b1, 32'hC1C1C1C1, 1'b0, 1'b0);
        step(1'b1, 32'hC2C2C2C2, 1'b1, 1'b0);
        step(1'b1, 32'hBAD0BAD0, 1'b0, 1'b0);
        step(1'b1, 32'hBAD1BAD1, 1'b0, 1'b0);
        chk("t5_queued_valid", 32'(out_valid), 32'd1);
        fd0 = fd_seen;
        in_valid = 1'b0; in_done = 1'b0; out_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t5_word_cnt", 32'(word_cnt), 32'd0);
        chk("t5_no_fd", 32'(fd_seen - fd0), 32'd0);
        chk("t5_no_words", 32'(log_d.size()), 32'd0);
        chk("t5_ovf_cleared", 32'(overflow), 32'd0);

        // Random layers: random mode (changed mid-layer too), gaps and stalls.
        for (int l = 0; l < 16; l++) begin
            nb = $urandom_range(1, 11);
            cc = $urandom_range(0, 1);
            for (int b = 0; b < nb; b++) begin
                while (($urandom % 4) == 0) begin
                    mode = 1'($urandom_range(0, 1));
                    step(1'b0, 32'h0, 1'b0, rnd_ready());
                end
                mode = 1'($urandom_range(0, 1));
                step(1'b1, $urandom, (b == nb - 1) && cc, rnd_ready());
            end
            if (!cc) step(1'b0, 32'h0, 1'b1, rnd_ready());
            wait_fd(200, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
